// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared constants and types for the UART order framer
package uart_frame_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES  = 7;
    localparam int         BODY_BYTES   = 5;

    typedef enum logic [1:0] {HUNT, BODY, CHECK} frm_state_t;

    typedef struct packed {
        logic [7:0]  mtype;
        logic [7:0]  id;
        logic [15:0] price;
        logic [7:0]  qty;
    } order_msg_t;

endpackage

// File: rtl/framer_gap_timer.sv
// framer_gap_timer: inter-byte gap counter that clears on activity and flags expiry at LIMIT-1
module framer_gap_timer #(
    parameter logic [23:0] LIMIT = 24'd17360
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [23:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == LIMIT - 24'd1);

    // count while enabled, restart on a byte or on expiry
    always_comb begin
        cnt_d = (clr_i || expire_o) ? '0 : en_i ? cnt_q + 24'd1 : cnt_q;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_order_framer.sv
// uart_order_framer: sync hunt, 7-byte order framing, XOR check, one-slot output; FRAMER_TIMEOUT_EN adds gap timeout
module uart_order_framer
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FREQ      = 100000000,
    parameter int         BAUD_RATE     = 115200,
    parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
    parameter int         TIMEOUT_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [7:0]  msg_type,
    output logic [7:0]  msg_id,
    output logic [15:0] msg_price,
    output logic [7:0]  msg_qty,
    output logic [7:0]  err_chk,
    output logic [7:0]  err_ovf,
    output logic [7:0]  err_tmo
);

    frm_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] stg_q [BODY_BYTES];
    logic [7:0] stg_d [BODY_BYTES];
    order_msg_t msg_q, msg_d;
    logic       valid_q, valid_d;
    logic [7:0] chk_q, ovf_q;
    logic       commit, bad, load, drop, tmo;

`ifdef FRAMER_TIMEOUT_EN
    localparam int CYCLES_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CYCLES_PER_BIT;

    logic       expire;
    logic [7:0] tmo_q;

    framer_gap_timer #(.LIMIT(24'(TIMEOUT_CYCLES))) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (rx_ready),
        .en_i     (state_q != HUNT),
        .expire_o (expire)
    );

    // a byte arriving on the expiry cycle takes precedence over the timeout
    assign tmo     = expire && !rx_ready;
    assign err_tmo = tmo_q;

    // saturating timeout counter
    always_ff @(posedge clk) begin
        if (rst)                       tmo_q <= '0;
        else if (tmo && tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
    end
`else
    assign tmo     = 1'b0;
    assign err_tmo = 8'd0;
`endif

    // framing state machine: hunt for sync, collect body, verify checksum
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        stg_d   = stg_q;
        commit  = 1'b0;
        bad     = 1'b0;
        if (rx_ready) begin
            case (state_q)
                HUNT: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = BODY;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                BODY: begin
                    stg_d[idx_q] = rx_data;
                    acc_d        = acc_q ^ rx_data;
                    idx_d        = (idx_q == 3'(BODY_BYTES - 1)) ? 3'd0 : idx_q + 3'd1;
                    state_d      = (idx_q == 3'(BODY_BYTES - 1)) ? CHECK : BODY;
                end
                CHECK: begin
                    commit  = (rx_data == acc_q);
                    bad     = (rx_data != acc_q);
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (tmo) begin
            state_d = HUNT;
            idx_d   = '0;
            acc_d   = '0;
        end
    end

    // output slot: load when free or being drained this cycle, otherwise drop
    always_comb begin
        load    = commit && (!valid_q || msg_ready);
        drop    = commit && !load;
        msg_d   = load ? {stg_q[0], stg_q[1], stg_q[2], stg_q[3], stg_q[4]} : msg_q;
        valid_d = load ? 1'b1 : (valid_q && msg_ready) ? 1'b0 : valid_q;
    end

    // state, staging, output slot and saturating error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
            acc_q   <= '0;
            stg_q   <= '{default: '0};
            msg_q   <= '0;
            valid_q <= 1'b0;
            chk_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            stg_q   <= stg_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            if (bad && chk_q != 8'hFF)  chk_q <= chk_q + 8'd1;
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    assign msg_valid = valid_q;
    assign msg_type  = msg_q.mtype;
    assign msg_id    = msg_q.id;
    assign msg_price = msg_q.price;
    assign msg_qty   = msg_q.qty;
    assign err_chk   = chk_q;
    assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_order_framer.sv
// tb_uart_order_framer: scoreboard bench for the order framer
module tb_uart_order_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_type, msg_id, msg_qty;
    logic [15:0] msg_price;
    logic [7:0]  err_chk, err_ovf, err_tmo;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q [$];

    always #5 clk = ~clk;

    uart_order_framer dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_type  (msg_type),
        .msg_id    (msg_id),
        .msg_price (msg_price),
        .msg_qty   (msg_qty),
        .err_chk   (err_chk),
        .err_ovf   (err_ovf),
        .err_tmo   (err_tmo)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every accepted message must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && msg_valid === 1'b1 && msg_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg: got %h expected none",
                             {msg_type, msg_id, msg_price, msg_qty});
                end else begin
                    check("msg", {msg_type, msg_id, msg_price, msg_qty}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic frame(input logic [39:0] f, input bit corrupt, input bit rdy_at_chk);
        logic [7:0] c;
        c = f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0] ^ {7'd0, corrupt};
        send(8'hA5);
        send(f[39:32]);
        send(f[31:24]);
        send(f[23:16]);
        send(f[15:8]);
        send(f[7:0]);
        if (rdy_at_chk) msg_ready = 1'b1;
        send(c);
    endtask

    localparam logic [39:0] F0 = 40'h01_07_1234_0A;
    localparam logic [39:0] F1 = 40'h02_09_ABCD_11;
    localparam logic [39:0] F2 = 40'h03_10_00FF_05;
    localparam logic [39:0] F3 = 40'h04_20_55AA_01;
    localparam logic [39:0] F4 = 40'h05_A5_A500_07;
    localparam logic [39:0] F5 = 40'h06_33_0102_7F;
    localparam logic [39:0] F6 = 40'h07_44_FEDC_20;

    initial begin
        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        msg_ready = 1'b0;
        tick(3);
        check("reset_valid", {39'd0, msg_valid}, 40'd0);
        check("reset_fields", {msg_type, msg_id, msg_price, msg_qty}, 40'd0);
        check("reset_errs", {16'd0, err_chk, err_ovf, err_tmo}, 40'd0);
        rst = 1'b0;
        tick(1);

        msg_ready = 1'b1;
        send(8'h00);
        send(8'h3C);
        exp_q.push_back(F0);
        frame(F0, 1'b0, 1'b0);
        tick(2);
        check("good_errs", {16'd0, err_chk, err_ovf, err_tmo}, 40'd0);
        check("good_valid_drops", {39'd0, msg_valid}, 40'd0);

        frame(F0, 1'b1, 1'b0);
        tick(2);
        check("bad_chk_count", {32'd0, err_chk}, 40'd1);
        exp_q.push_back(F1);
        frame(F1, 1'b0, 1'b0);
        tick(2);
        check("after_bad_queue", exp_q.size(), 40'd0);

        msg_ready = 1'b0;
        exp_q.push_back(F2);
        frame(F2, 1'b0, 1'b0);
        frame(F3, 1'b0, 1'b0);
        tick(3);
        check("bp_valid", {39'd0, msg_valid}, 40'd1);
        check("bp_held", {msg_type, msg_id, msg_price, msg_qty}, F2);
        check("bp_ovf", {32'd0, err_ovf}, 40'd1);
        msg_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", {39'd0, msg_valid}, 40'd0);

        msg_ready = 1'b0;
        exp_q.push_back(F4);
        frame(F4, 1'b0, 1'b0);
        tick(2);
        check("sim_first_held", {msg_type, msg_id, msg_price, msg_qty}, F4);
        exp_q.push_back(F5);
        frame(F5, 1'b0, 1'b1);
        tick(2);
        check("sim_ovf", {32'd0, err_ovf}, 40'd1);
        check("sim_queue", exp_q.size(), 40'd0);
        check("sim_valid_drop", {39'd0, msg_valid}, 40'd0);

`ifdef FRAMER_TIMEOUT_EN
        send(8'hA5);
        send(8'h01);
        send(8'h07);
        tick(2 * 10 * 868 + 4);
        check("tmo_count", {32'd0, err_tmo}, 40'd1);
        exp_q.push_back(F6);
        frame(F6, 1'b0, 1'b0);
        tick(2);
        check("tmo_next_frame", exp_q.size(), 40'd0);
`else
        check("tmo_tied", {32'd0, err_tmo}, 40'd0);
`endif

        msg_ready = 1'b0;
        frame(F6, 1'b1, 1'b0);
        frame(F6, 1'b0, 1'b0);
        send(8'hA5);
        send(8'h11);
        rst = 1'b1;
        tick(2);
        check("rst_valid", {39'd0, msg_valid}, 40'd0);
        check("rst_fields", {msg_type, msg_id, msg_price, msg_qty}, 40'd0);
        check("rst_errs", {16'd0, err_chk, err_ovf, err_tmo}, 40'd0);
        rst = 1'b0;
        tick(1);
        msg_ready = 1'b1;
        exp_q.push_back(F1);
        frame(F1, 1'b0, 1'b0);
        tick(2);
        check("rst_then_frame", exp_q.size(), 40'd0);

        for (int i = 0; i < 300; i++) frame(F0, 1'b1, 1'b0);
        tick(2);
        check("chk_saturate", {32'd0, err_chk}, 40'hFF);
        check("final_queue", exp_q.size(), 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
